pipe_ctrl: RTL

- Pipelined successor to the single-cycle RV32I control decoder.
- Decodes the ID-stage instruction into the team's standard control bundle (RegWrite, MemWrite, EXTOp, ALUOp, NPCOp, ALUSrc, WDSel, DMType), then carries it through the ID/EX, EX/MEM and MEM/WB control registers.
- Owns hazard handling for the 5-stage PCPU: load-use interlock, branch/jump flush, forwarding selects, and an optional multi-cycle MDU hold.

---
 rtl/pcpu_ctrl_pkg.sv | 97 +++++++++
 rtl/pipe_ctrl_dec.sv | 159 +++++++++++++++
 rtl/pipe_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pcpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pcpu_ctrl_pkg
// Shared definitions for the pipelined RV32I control path: opcode constants,
// the control-field encodings (ALUOp, EXTOp, NPCOp, WDSel, DMType), the
// ctrl_bundle record carried through the ID/EX, EX/MEM and MEM/WB registers,
// and small helpers used by the hazard logic.
// ---------------------------------------------------------------------------
package pcpu_ctrl_pkg;

    // Major opcodes
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // ALUOp encoding; branches reuse the compare codes, beq uses SUB + zero
    localparam logic [4:0] ALU_NOP    = 5'b00000;
    localparam logic [4:0] ALU_LUI    = 5'b00001;
    localparam logic [4:0] ALU_AUIPC  = 5'b00010;
    localparam logic [4:0] ALU_ADD    = 5'b00011;
    localparam logic [4:0] ALU_SUB    = 5'b00100;
    localparam logic [4:0] ALU_BNE    = 5'b00101;
    localparam logic [4:0] ALU_BLT    = 5'b00110;
    localparam logic [4:0] ALU_BGE    = 5'b00111;
    localparam logic [4:0] ALU_BLTU   = 5'b01000;
    localparam logic [4:0] ALU_BGEU   = 5'b01001;
    localparam logic [4:0] ALU_SLT    = 5'b01010;
    localparam logic [4:0] ALU_SLTU   = 5'b01011;
    localparam logic [4:0] ALU_XOR    = 5'b01100;
    localparam logic [4:0] ALU_OR     = 5'b01101;
    localparam logic [4:0] ALU_AND    = 5'b01110;
    localparam logic [4:0] ALU_SLL    = 5'b01111;
    localparam logic [4:0] ALU_SRL    = 5'b10000;
    localparam logic [4:0] ALU_SRA    = 5'b10001;
    // M ops: mul, mulh, mulhsu, mulhu, div, divu (ALU_MUL + funct3)
    localparam logic [4:0] ALU_MUL    = 5'b10010;
    localparam logic [4:0] ALU_DIVU   = 5'b10111;

    // EXTOp one-hot immediate selects
    localparam logic [5:0] EXT_SHAMT  = 6'b100000;
    localparam logic [5:0] EXT_ITYPE  = 6'b010000;
    localparam logic [5:0] EXT_STYPE  = 6'b001000;
    localparam logic [5:0] EXT_BTYPE  = 6'b000100;
    localparam logic [5:0] EXT_UTYPE  = 6'b000010;
    localparam logic [5:0] EXT_JTYPE  = 6'b000001;

    // NPCOp
    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    // WDSel
    localparam logic [1:0] WD_ALU     = 2'b00;
    localparam logic [1:0] WD_MEM     = 2'b01;
    localparam logic [1:0] WD_PC      = 2'b10;

    // DMType
    localparam logic [2:0] DM_WORD    = 3'b000;
    localparam logic [2:0] DM_HALF    = 3'b001;
    localparam logic [2:0] DM_HALFU   = 3'b010;
    localparam logic [2:0] DM_BYTE    = 3'b011;
    localparam logic [2:0] DM_BYTEU   = 3'b100;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memwrite;
        logic [5:0] extop;
        logic [4:0] aluop;
        logic [2:0] npcop;
        logic       alusrc;
        logic [1:0] wdsel;
        logic [2:0] dmtype;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs1;
        logic       uses_rs2;
    } ctrl_bundle;

    function automatic logic is_m_op(input logic [4:0] aluop);
        return (aluop >= ALU_MUL) && (aluop <= ALU_DIVU);
    endfunction

    // True when 'cons' actually reads register 'rd' (x0 never matches)
    function automatic logic reads_reg(input logic [4:0] rd, input ctrl_bundle cons);
        return (rd != 5'd0) &&
               ((cons.uses_rs1 && cons.rs1 == rd) || (cons.uses_rs2 && cons.rs2 == rd));
    endfunction

endpackage

// File: rtl/pipe_ctrl_dec.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_dec
// Purely combinational ID-stage decoder: turns one instruction into a
// ctrl_bundle. Anything that matches no decode row, or names a register
// outside the RF_AW-bit register file, comes out as a bubble with illegal=1.
// Ports:
//   valid   in   IF/ID holds a real instruction
//   instr   in   32-bit instruction
//   bundle  out  decoded control bundle, all-zero unless valid and legal
//   illegal out  valid instruction that failed to decode
// ---------------------------------------------------------------------------
module pipe_ctrl_dec
    import pcpu_ctrl_pkg::*;
#(
    parameter int RF_AW  = 5,
    parameter bit MDU_EN = 1'b0
) (
    input  logic        valid,
    input  logic [31:0] instr,
    output ctrl_bundle  bundle,
    output logic        illegal
);

    ctrl_bundle d;
    logic       legal;
    logic       writes_rd;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    function automatic logic addr_ok(input logic [4:0] a);
        return (a >> RF_AW) == 5'd0;
    endfunction

    // Row-by-row decode. Fields start at bubble values and each legal row
    // fills in what it needs; source addresses are only kept when used so
    // unused fields can never trigger a hazard or a forward.
    always_comb begin
        d         = '0;
        legal     = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OP_LUI: begin
                legal = 1'b1; writes_rd = 1'b1;
                d.extop = EXT_UTYPE; d.aluop = ALU_LUI; d.alusrc = 1'b1;
            end
            OP_AUIPC: begin
                legal = 1'b1; writes_rd = 1'b1;
                d.extop = EXT_UTYPE; d.aluop = ALU_AUIPC; d.alusrc = 1'b1;
            end
            OP_JAL: begin
                legal = 1'b1; writes_rd = 1'b1;
                d.extop = EXT_JTYPE; d.npcop = NPC_JUMP; d.wdsel = WD_PC;
            end
            OP_JALR: begin
                legal = (f3 == 3'b000); writes_rd = 1'b1; d.uses_rs1 = 1'b1;
                d.extop = EXT_ITYPE; d.aluop = ALU_ADD; d.alusrc = 1'b1;
                d.npcop = NPC_JALR; d.wdsel = WD_PC;
            end
            OP_BRANCH: begin
                legal = 1'b1; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1;
                d.extop = EXT_BTYPE; d.npcop = NPC_BRANCH;
                case (f3)
                    3'b000:  d.aluop = ALU_SUB;
                    3'b001:  d.aluop = ALU_BNE;
                    3'b100:  d.aluop = ALU_BLT;
                    3'b101:  d.aluop = ALU_BGE;
                    3'b110:  d.aluop = ALU_BLTU;
                    3'b111:  d.aluop = ALU_BGEU;
                    default: legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                legal = 1'b1; writes_rd = 1'b1; d.uses_rs1 = 1'b1;
                d.extop = EXT_ITYPE; d.aluop = ALU_ADD; d.alusrc = 1'b1;
                d.wdsel = WD_MEM;
                case (f3)
                    3'b000:  d.dmtype = DM_BYTE;
                    3'b001:  d.dmtype = DM_HALF;
                    3'b010:  d.dmtype = DM_WORD;
                    3'b100:  d.dmtype = DM_BYTEU;
                    3'b101:  d.dmtype = DM_HALFU;
                    default: legal = 1'b0;
                endcase
            end
            OP_STORE: begin
                legal = 1'b1; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1;
                d.extop = EXT_STYPE; d.aluop = ALU_ADD; d.alusrc = 1'b1;
                d.memwrite = 1'b1;
                case (f3)
                    3'b000:  d.dmtype = DM_BYTE;
                    3'b001:  d.dmtype = DM_HALF;
                    3'b010:  d.dmtype = DM_WORD;
                    default: legal = 1'b0;
                endcase
            end
            OP_IMM: begin
                legal = 1'b1; writes_rd = 1'b1; d.uses_rs1 = 1'b1;
                d.extop = EXT_ITYPE; d.alusrc = 1'b1;
                case (f3)
                    3'b000: d.aluop = ALU_ADD;
                    3'b010: d.aluop = ALU_SLT;
                    3'b011: d.aluop = ALU_SLTU;
                    3'b100: d.aluop = ALU_XOR;
                    3'b110: d.aluop = ALU_OR;
                    3'b111: d.aluop = ALU_AND;
                    3'b001: begin
                        d.extop = EXT_SHAMT; d.aluop = ALU_SLL;
                        legal = (f7 == 7'b0000000);
                    end
                    default: begin
                        d.extop = EXT_SHAMT;
                        d.aluop = f7[5] ? ALU_SRA : ALU_SRL;
                        legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    end
                endcase
            end
            OP_REG: begin
                writes_rd = 1'b1; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1;
                if (f7 == 7'b0000000) begin
                    legal = 1'b1;
                    case (f3)
                        3'b000:  d.aluop = ALU_ADD;
                        3'b001:  d.aluop = ALU_SLL;
                        3'b010:  d.aluop = ALU_SLT;
                        3'b011:  d.aluop = ALU_SLTU;
                        3'b100:  d.aluop = ALU_XOR;
                        3'b101:  d.aluop = ALU_SRL;
                        3'b110:  d.aluop = ALU_OR;
                        default: d.aluop = ALU_AND;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    legal   = (f3 == 3'b000) || (f3 == 3'b101);
                    d.aluop = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
                end else if (f7 == 7'b0000001 && MDU_EN) begin
                    // Only six M-op codes exist, so rem/remu stay illegal
                    legal   = (f3 <= 3'b101);
                    d.aluop = ALU_MUL + {2'b00, f3};
                end
            end
            default: legal = 1'b0;
        endcase

        if (writes_rd)  d.rd  = instr[11:7];
        if (d.uses_rs1) d.rs1 = instr[19:15];
        if (d.uses_rs2) d.rs2 = instr[24:20];
        if (!addr_ok(d.rd) || !addr_ok(d.rs1) || !addr_ok(d.rs2)) legal = 1'b0;
        d.regwrite = writes_rd && (d.rd != 5'd0);
        d.valid    = 1'b1;
    end

    assign bundle  = (valid && legal) ? d : '0;
    assign illegal = valid && !legal;

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Control path of the 5-stage PCPU: decodes the ID instruction, carries the
// control bundle through ID/EX, EX/MEM and MEM/WB, and produces the stall,
// flush and forwarding selects (load-use interlock or full RAW interlock,
// EX-resolved branch/jump flush, optional multi-cycle MDU hold).
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   id_valid, id_instr   instruction currently in ID
//   ex_zero              branch-condition result of the EX instruction
//   ex_*                 ID/EX controls (ex_npcop is BRANCH only when taken)
//   mem_*                EX/MEM controls
//   wb_*                 MEM/WB controls
//   fwd_a, fwd_b         operand selects: 00 RF, 01 EX/MEM, 10 MEM/WB
//   stall                hold PC and IF/ID
//   flush                squash IF/ID
//   illegal              one-cycle pulse when an illegal instruction enters EX
// ---------------------------------------------------------------------------
module pipe_ctrl
    import pcpu_ctrl_pkg::*;
#(
    parameter int RF_AW   = 5,
    parameter bit FWD_EN  = 1'b1,
    parameter bit MDU_EN  = 1'b0,
    parameter int MDU_LAT = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic             ex_zero,
    output logic [RF_AW-1:0] ex_rs1,
    output logic [RF_AW-1:0] ex_rs2,
    output logic [4:0]       ex_aluop,
    output logic             ex_alusrc,
    output logic [5:0]       ex_extop,
    output logic [2:0]       ex_npcop,
    output logic             mem_memwrite,
    output logic [2:0]       mem_dmtype,
    output logic             wb_regwrite,
    output logic [1:0]       wb_wdsel,
    output logic [RF_AW-1:0] wb_rd,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic             flush,
    output logic             illegal
);

    ctrl_bundle id_b, ex_q, mem_q, wb_q;
    ctrl_bundle ex_d, mem_d;
    logic       id_illegal, ex_illegal_q, ex_illegal_d;
    logic [3:0] mdu_cnt_q, mdu_cnt_d;
    logic       mdu_hold, taken, hazard;

    pipe_ctrl_dec #(.RF_AW(RF_AW), .MDU_EN(MDU_EN)) u_dec (
        .valid   (id_valid),
        .instr   (id_instr),
        .bundle  (id_b),
        .illegal (id_illegal)
    );

    // Hazard resolution and next-state selection. The MDU hold is checked
    // first: while it runs EX is frozen, so a control transfer cannot be
    // taken and nothing new may enter ID/EX. A taken transfer then beats an
    // interlock, since the instruction being held in ID is on the wrong path.
    always_comb begin
        mdu_hold = MDU_EN && (mdu_cnt_q != 4'd0);
        taken    = !mdu_hold && ex_q.valid &&
                   ((ex_q.npcop == NPC_BRANCH && ex_zero) ||
                    ex_q.npcop == NPC_JUMP || ex_q.npcop == NPC_JALR);

        if (FWD_EN)
            hazard = ex_q.valid && (ex_q.wdsel == WD_MEM) && reads_reg(ex_q.rd, id_b);
        else
            hazard = (ex_q.regwrite  && reads_reg(ex_q.rd,  id_b)) ||
                     (mem_q.regwrite && reads_reg(mem_q.rd, id_b)) ||
                     (wb_q.regwrite  && reads_reg(wb_q.rd,  id_b));

        stall = mdu_hold || (hazard && !taken);
        flush = taken;

        ex_d         = '0;
        ex_illegal_d = 1'b0;
        if (mdu_hold) begin
            ex_d = ex_q;
        end else if (!taken && !hazard) begin
            ex_d         = id_b;
            ex_illegal_d = id_illegal;
        end

        mem_d = mdu_hold ? '0 : ex_q;

        // The counter loads only when an M op newly enters EX, not on the
        // release cycle of the previous hold.
        mdu_cnt_d = 4'd0;
        if (mdu_hold)
            mdu_cnt_d = mdu_cnt_q - 4'd1;
        else if (MDU_EN && ex_d.valid && is_m_op(ex_d.aluop))
            mdu_cnt_d = 4'(MDU_LAT - 1);
    end

    // Stage registers and MDU counter; reset turns every stage into a bubble
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            ex_illegal_q <= 1'b0;
            mdu_cnt_q    <= 4'd0;
        end else begin
            ex_q         <= ex_d;
            mem_q        <= mem_d;
            wb_q         <= mem_q;
            ex_illegal_q <= ex_illegal_d;
            mdu_cnt_q    <= mdu_cnt_d;
        end
    end

    // Forwarding selects: the younger EX/MEM result wins over MEM/WB
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (FWD_EN) begin
            if (mem_q.regwrite && mem_q.rd != 5'd0 && mem_q.rd == ex_q.rs1)
                fwd_a = 2'b01;
            else if (wb_q.regwrite && wb_q.rd != 5'd0 && wb_q.rd == ex_q.rs1)
                fwd_a = 2'b10;
            if (mem_q.regwrite && mem_q.rd != 5'd0 && mem_q.rd == ex_q.rs2)
                fwd_b = 2'b01;
            else if (wb_q.regwrite && wb_q.rd != 5'd0 && wb_q.rd == ex_q.rs2)
                fwd_b = 2'b10;
        end
    end

    assign ex_rs1       = ex_q.rs1[RF_AW-1:0];
    assign ex_rs2       = ex_q.rs2[RF_AW-1:0];
    assign ex_aluop     = ex_q.aluop;
    assign ex_alusrc    = ex_q.alusrc;
    assign ex_extop     = ex_q.extop;
    assign ex_npcop     = (ex_q.npcop == NPC_BRANCH && !ex_zero) ? NPC_PLUS4 : ex_q.npcop;
    assign mem_memwrite = mem_q.memwrite;
    assign mem_dmtype   = mem_q.dmtype;
    assign wb_regwrite  = wb_q.regwrite;
    assign wb_wdsel     = wb_q.wdsel;
    assign wb_rd        = wb_q.rd[RF_AW-1:0];
    assign illegal      = ex_illegal_q;

endmodule
